// File: rtl/fp_divider_single_precision_seq_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fp_divider_single_precision_seq_if                                    |
// | Start/valid request bus of the iterative FP divider                   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface fp_divider_single_precision_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Busy;
    logic         Out_Valid;
    logic [W-1:0] Div_Out;

    modport master (
        output Start, A, B,
        input  Busy, Out_Valid, Div_Out
    );

    modport slave (
        input  Start, A, B,
        output Busy, Out_Valid, Div_Out
    );
endinterface
`default_nettype wire

// File: rtl/fp_divider_single_precision_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fp_divider_single_precision_seq                                       |
// | Restoring radix-2 IEEE-754 divider, one quotient bit per clock        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module fp_divider_single_precision_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127
) (
    input  wire logic                        clk,
    input  wire logic                        rst_n,
    fp_divider_single_precision_seq_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int N  = MAN_W + 2;
    localparam int CW = $clog2(N + 1);
    localparam int EW = EXP_W + 2;
    localparam logic [EXP_W-1:0]        EXP_MAX = '1;
    localparam logic signed [EW-1:0]    EXP_TOP = EW'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_NORM = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   sign_q, sign_d;
    logic signed [EW-1:0]   exp_q, exp_d;
    logic [N-1:0]           rem_q, rem_d;
    logic [MAN_W:0]         div_q, div_d;
    logic [N-1:0]           quo_q, quo_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   spec_q, spec_d;
    logic [W-1:0]           spec_res_q, spec_res_d;
    logic [W-1:0]           out_q, out_d;
    logic                   valid_q, valid_d;

    // Operand decode; exponent 0 covers denormals, which are flushed to zero
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, in_sign;
    logic             nan_c, inf_c, zero_c;
    logic [EW-1:0]    e_calc;

    assign a_exp   = bus.A[W-2:MAN_W];
    assign b_exp   = bus.B[W-2:MAN_W];
    assign a_man   = bus.A[MAN_W-1:0];
    assign b_man   = bus.B[MAN_W-1:0];
    assign in_sign = bus.A[W-1] ^ bus.B[W-1];
    assign a_zero  = (a_exp == '0);
    assign b_zero  = (b_exp == '0);
    assign a_inf   = (a_exp == EXP_MAX) && (a_man == '0);
    assign b_inf   = (b_exp == EXP_MAX) && (b_man == '0);
    assign a_nan   = (a_exp == EXP_MAX) && (a_man != '0);
    assign b_nan   = (b_exp == EXP_MAX) && (b_man != '0);
    assign nan_c   = a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf);
    assign inf_c   = a_inf || b_zero;
    assign zero_c  = a_zero || b_inf;
    assign e_calc  = EW'(a_exp) - EW'(b_exp) + EW'(BIAS);

    // Divide step
    logic         step_ge;
    logic [N-1:0] step_sel;
    assign step_ge  = (rem_q >= {1'b0, div_q});
    assign step_sel = step_ge ? (rem_q - {1'b0, div_q}) : rem_q;

    // Normalisation: quotient lies in (0.5, 2), so at most one bit of shift
    logic signed [EW-1:0] exp_n;
    logic [MAN_W-1:0]     mant_n;
    logic                 ovf_n, unf_n;
    logic [W-1:0]         norm_res;

    assign exp_n  = quo_q[N-1] ? exp_q : exp_q - EW'(1);
    assign mant_n = quo_q[N-1] ? quo_q[MAN_W:1] : quo_q[MAN_W-1:0];
    assign ovf_n  = (exp_n >= EXP_TOP);
    assign unf_n  = exp_n[EW-1] || (exp_n == '0);

    always_comb begin
        norm_res = {sign_q, exp_n[EXP_W-1:0], mant_n};
        if (spec_q)     norm_res = spec_res_q;
        else if (ovf_n) norm_res = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
        else if (unf_n) norm_res = {sign_q, {(W-1){1'b0}}};
    end

    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        rem_d      = rem_q;
        div_d      = div_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        out_d      = out_q;
        valid_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    state_d = S_DIV;
                    sign_d  = in_sign;
                    exp_d   = e_calc;
                    rem_d   = {2'b01, a_man};
                    div_d   = {1'b1, b_man};
                    quo_d   = '0;
                    cnt_d   = '0;
                    spec_d  = nan_c || inf_c || zero_c;
                    if (nan_c)
                        spec_res_d = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
                    else if (inf_c)
                        spec_res_d = {in_sign, EXP_MAX, {MAN_W{1'b0}}};
                    else
                        spec_res_d = {in_sign, {(W-1){1'b0}}};
                end
            end
            S_DIV: begin
                quo_d = {quo_q[N-2:0], step_ge};
                rem_d = step_sel << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1))
                    state_d = S_NORM;
            end
            S_NORM: begin
                out_d   = norm_res;
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            rem_q      <= '0;
            div_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            out_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            rem_q      <= rem_d;
            div_q      <= div_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.Busy      = (state_q != S_IDLE);
    assign bus.Out_Valid = valid_q;
    assign bus.Div_Out   = out_q;
endmodule
`default_nettype wire
